// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Resolves branches/jumps from comparator flags; registered stage
//            with 1-entry skid buffer. Optional counters: BRANCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_valid,
    output logic                  out_ready,
    input  logic [4:0]            in_flag,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_jump,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic                  in_pred_taken,
    input  logic [DATA_WIDTH-1:0] in_pred_target,
    input  logic                  in_flush,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic                  out_taken,
    output logic [DATA_WIDTH-1:0] out_pc_next,
    output logic                  out_mispredict,
    output logic                  out_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           out_branch_cnt,
    output logic [31:0]           out_mispredict_cnt
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  taken;
        logic [DATA_WIDTH-1:0] pc_next;
        logic                  mispredict;
        logic                  illegal;
    } res_t;

    localparam logic [DATA_WIDTH-1:0] C_INSN_BYTES = DATA_WIDTH'(4);

    state_t state_q, state_d;
    res_t   main_q, main_d;
    res_t   skid_q, skid_d;
    logic   ready_q;
    res_t   res_new;
    logic   cond;
    logic   illegal;
    logic   taken;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] fall_thru;
    logic   accept;
    logic   xfer;
    logic   unused_flag;

    // Flags [1:0] carry no branch information.
    assign unused_flag = ^in_flag[1:0];

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        unique case (in_funct3)
            3'b000:  cond = in_flag[4];
            3'b001:  cond = ~in_flag[4];
            3'b100:  cond = in_flag[3];
            3'b101:  cond = ~in_flag[3];
            3'b110:  cond = in_flag[2];
            3'b111:  cond = ~in_flag[2];
            default: illegal = 1'b1;
        endcase
    end

    assign target    = in_pc + in_imm;
    assign fall_thru = in_pc + C_INSN_BYTES;
    assign taken     = in_is_jump | (cond & ~illegal);

    always_comb begin
        res_new.taken      = taken;
        res_new.pc_next    = taken ? target : fall_thru;
        res_new.illegal    = illegal & ~in_is_jump;
        // An illegal entry is never taken, so this reduces to in_pred_taken.
        res_new.mispredict = (taken != in_pred_taken) |
                             (taken & in_pred_taken & (target != in_pred_target));
    end

    assign out_valid = (state_q != S_EMPTY);
    assign out_ready = ready_q;
    assign accept    = in_valid & ready_q;
    assign xfer      = out_valid & in_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    main_d  = res_new;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && xfer) begin
                    main_d = res_new;
                end else if (accept) begin
                    skid_d  = res_new;
                    state_d = S_TWO;
                end else if (xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (xfer) begin
                    main_d  = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (in_flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= (state_d != S_TWO);
        end
    end

    assign out_taken      = main_q.taken;
    assign out_pc_next    = main_q.pc_next;
    assign out_mispredict = main_q.mispredict;
    assign out_illegal    = main_q.illegal;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] misp_cnt_q;

    // A transfer in a flush cycle still counts; discarded entries never transfer.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            branch_cnt_q <= '0;
            misp_cnt_q   <= '0;
        end else if (xfer) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (main_q.mispredict) begin
                misp_cnt_q <= misp_cnt_q + 32'd1;
            end
        end
    end

    assign out_branch_cnt     = branch_cnt_q;
    assign out_mispredict_cnt = misp_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve
// Purpose  : Self-checking bench: directed vector table, handshake sequences
//            and randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve;

    localparam int DW = 64;

    logic          in_clk = 1'b0;
    logic          in_rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [4:0]    in_flag;
    logic [2:0]    in_funct3;
    logic          in_is_jump;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_imm;
    logic          in_pred_taken;
    logic [DW-1:0] in_pred_target;
    logic          in_flush;
    logic          out_valid;
    logic          in_ready;
    logic          out_taken;
    logic [DW-1:0] out_pc_next;
    logic          out_mispredict;
    logic          out_illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0]   out_branch_cnt;
    logic [31:0]   out_mispredict_cnt;
`endif

    branch_resolve #(.DATA_WIDTH(DW)) dut (
        .in_clk         (in_clk),
        .in_rst_n       (in_rst_n),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_flag        (in_flag),
        .in_funct3      (in_funct3),
        .in_is_jump     (in_is_jump),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .in_flush       (in_flush),
        .out_valid      (out_valid),
        .in_ready       (in_ready),
        .out_taken      (out_taken),
        .out_pc_next    (out_pc_next),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal)
`ifdef BRANCH_STATS_EN
        ,
        .out_branch_cnt     (out_branch_cnt),
        .out_mispredict_cnt (out_mispredict_cnt)
`endif
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic          taken;
        logic [DW-1:0] pc_next;
        logic          misp;
        logic          ill;
    } res_t;

    typedef struct {
        logic [4:0]    flag;
        logic [2:0]    f3;
        logic          jump;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic          pt;
        logic [DW-1:0] ptgt;
        logic          e_taken;
        logic [DW-1:0] e_pc;
        logic          e_misp;
        logic          e_ill;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    res_t        mq[$];
    logic [31:0] exp_cnt  = 0;
    logic [31:0] exp_mcnt = 0;
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: branch semantics straight from the ISA rules.
    function automatic res_t ref_model(input logic [4:0] flag, input logic [2:0] f3,
                                       input logic jump, input logic [DW-1:0] pc,
                                       input logic [DW-1:0] imm, input logic pt,
                                       input logic [DW-1:0] ptgt);
        res_t          r;
        logic [DW-1:0] tgt;
        bit            eq, lt, ltu, tk, il;
        eq  = flag[4];
        lt  = flag[3];
        ltu = flag[2];
        il  = 0;
        tk  = 0;
        if (jump) tk = 1;
        else if (f3 == 3'd0) tk = eq;
        else if (f3 == 3'd1) tk = !eq;
        else if (f3 == 3'd4) tk = lt;
        else if (f3 == 3'd5) tk = !lt;
        else if (f3 == 3'd6) tk = ltu;
        else if (f3 == 3'd7) tk = !ltu;
        else il = 1;
        tgt       = pc + imm;
        r.taken   = tk;
        r.ill     = il;
        r.pc_next = tk ? tgt : pc + 64'd4;
        r.misp    = il ? pt : ((tk != pt) || (tk && pt && tgt != ptgt));
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, DW'(out_valid), DW'(mq.size() > 0));
        chk({tag, "_ready"}, DW'(out_ready), DW'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk({tag, "_taken"}, DW'(out_taken), DW'(mq[0].taken));
            chk({tag, "_pcnext"}, out_pc_next, mq[0].pc_next);
            chk({tag, "_misp"}, DW'(out_mispredict), DW'(mq[0].misp));
            chk({tag, "_ill"}, DW'(out_illegal), DW'(mq[0].ill));
        end
`ifdef BRANCH_STATS_EN
        chk({tag, "_bcnt"}, DW'(out_branch_cnt), DW'(exp_cnt));
        chk({tag, "_mcnt"}, DW'(out_mispredict_cnt), DW'(exp_mcnt));
`endif
    endtask

    // One clock with the currently driven inputs; model updated and compared.
    task automatic step(input string tag);
        bit   acc, xfer;
        res_t r;
        acc  = in_valid && (mq.size() < 2);
        xfer = (mq.size() > 0) && in_ready;
        r = ref_model(in_flag, in_funct3, in_is_jump, in_pc, in_imm, in_pred_taken, in_pred_target);
        @(posedge in_clk);
        if (xfer) begin
            exp_cnt++;
            if (mq[0].misp) exp_mcnt++;
            void'(mq.pop_front());
        end
        if (in_flush) mq.delete();
        else if (acc) mq.push_back(r);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive_req(input logic [DW-1:0] pc, input logic [DW-1:0] imm);
        in_valid       = 1'b1;
        in_flag        = 5'b00000;
        in_funct3      = 3'b000;
        in_is_jump     = 1'b1;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = 1'b1;
        in_pred_target = pc + imm;
    endtask

    initial begin
        //            flag      f3    jmp  pc                      imm                     pt   ptgt                   tk   pc_next                 misp ill
        tbl[0]  = '{5'b10000, 3'b000, 1'b0, 64'h1000,              64'h40,                 1'b0, 64'h0,                 1'b1, 64'h1040,              1'b1, 1'b0};
        tbl[1]  = '{5'b01000, 3'b101, 1'b0, 64'h2000,              64'h100,                1'b0, 64'h0,                 1'b0, 64'h2004,              1'b0, 1'b0};
        tbl[2]  = '{5'b01011, 3'b101, 1'b0, 64'h2000,              64'h100,                1'b0, 64'h0,                 1'b0, 64'h2004,              1'b0, 1'b0};
        tbl[3]  = '{5'b00100, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8,                1'b1, 64'h4,                 1'b1, 64'h4,                 1'b0, 1'b0};
        tbl[4]  = '{5'b00000, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8,                1'b1, 64'h4,                 1'b0, 64'h0,                 1'b1, 1'b0};
        tbl[5]  = '{5'b10000, 3'b010, 1'b0, 64'h3000,              64'h10,                 1'b1, 64'h3010,              1'b0, 64'h3004,              1'b1, 1'b1};
        tbl[6]  = '{5'b10000, 3'b010, 1'b1, 64'h3000,              64'h10,                 1'b1, 64'h3010,              1'b1, 64'h3010,              1'b0, 1'b0};
        tbl[7]  = '{5'b00000, 3'b000, 1'b1, 64'h3000,              64'h10,                 1'b1, 64'h3020,              1'b1, 64'h3010,              1'b1, 1'b0};
        tbl[8]  = '{5'b10000, 3'b001, 1'b0, 64'h4000,              64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h0,                1'b0, 64'h4004,              1'b0, 1'b0};
        tbl[9]  = '{5'b01000, 3'b100, 1'b0, 64'h5000,              64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h4FF0,             1'b1, 64'h4FF0,              1'b0, 1'b0};
        tbl[10] = '{5'b00100, 3'b111, 1'b0, 64'h6000,              64'h80,                 1'b1, 64'h6080,              1'b0, 64'h6004,              1'b1, 1'b0};
        tbl[11] = '{5'b11111, 3'b011, 1'b0, 64'h7000,              64'h20,                 1'b0, 64'h0,                 1'b0, 64'h7004,              1'b0, 1'b1};

        in_rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0; in_flush = 1'b0;
        in_flag = '0; in_funct3 = '0; in_is_jump = 1'b0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0;
        #22;
        chk("rst_valid", DW'(out_valid), 0);
        chk("rst_ready", DW'(out_ready), 1);
        chk("rst_taken", DW'(out_taken), 0);
        chk("rst_pcnext", out_pc_next, 0);
        chk("rst_misp", DW'(out_mispredict), 0);
        chk("rst_ill", DW'(out_illegal), 0);
        in_rst_n = 1'b1;

        // Directed vector table: accept, inspect held result, drain.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_ready = 1'b0;
            in_flag = tbl[i].flag; in_funct3 = tbl[i].f3; in_is_jump = tbl[i].jump;
            in_pc = tbl[i].pc; in_imm = tbl[i].imm;
            in_pred_taken = tbl[i].pt; in_pred_target = tbl[i].ptgt;
            step("vec");
            chk($sformatf("vec%0d_valid", i), DW'(out_valid), 1);
            chk($sformatf("vec%0d_taken", i), DW'(out_taken), DW'(tbl[i].e_taken));
            chk($sformatf("vec%0d_pcnext", i), out_pc_next, tbl[i].e_pc);
            chk($sformatf("vec%0d_misp", i), DW'(out_mispredict), DW'(tbl[i].e_misp));
            chk($sformatf("vec%0d_ill", i), DW'(out_illegal), DW'(tbl[i].e_ill));
            in_valid = 1'b0; in_ready = 1'b1;
            step("vecdrain");
            chk($sformatf("vec%0d_drained", i), DW'(out_valid), 0);
        end

        // Backpressure: three back-to-back requests with the consumer stalled.
        in_ready = 1'b0;
        drive_req(64'h100, 64'h10); step("bp");
        chk("bp_a_pc", out_pc_next, 64'h110);
        chk("bp_a_ready", DW'(out_ready), 1);
        drive_req(64'h200, 64'h10); step("bp");
        chk("bp_b_ready", DW'(out_ready), 0);
        drive_req(64'h300, 64'h10); step("bp");
        chk("bp_c_stall_ready", DW'(out_ready), 0);
        chk("bp_c_stall_pc", out_pc_next, 64'h110);
        in_ready = 1'b1; step("bp");
        chk("bp_out_b", out_pc_next, 64'h210);
        chk("bp_ready_back", DW'(out_ready), 1);
        step("bp");
        chk("bp_out_c", out_pc_next, 64'h310);
        in_valid = 1'b0; step("bp");
        chk("bp_empty", DW'(out_valid), 0);

        // Flush from the full state with a concurrent request.
        in_ready = 1'b0;
        drive_req(64'h400, 64'h8); step("fl");
        drive_req(64'h500, 64'h8); step("fl");
        chk("fl_full_ready", DW'(out_ready), 0);
        drive_req(64'h600, 64'h8); in_flush = 1'b1; step("fl");
        chk("fl_valid", DW'(out_valid), 0);
        chk("fl_ready", DW'(out_ready), 1);
        in_flush = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("flpost");
            chk("fl_never_appears", DW'(out_valid), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b;
            b              = 8'($urandom);
            in_valid       = ($urandom_range(0, 3) != 0);
            in_ready       = ($urandom_range(0, 3) != 0);
            in_flush       = ($urandom_range(0, 31) == 0);
            in_flag        = 5'($urandom);
            in_funct3      = 3'($urandom_range(0, 7));
            in_is_jump     = ($urandom_range(0, 7) == 0);
            in_pc          = ($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FF00 | 64'(b))
                                                         : {$urandom(), $urandom()};
            in_imm         = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()}
                                                         : {{56{b[7]}}, b};
            in_pred_taken  = 1'($urandom);
            in_pred_target = ($urandom_range(0, 1) == 0) ? in_pc + in_imm : {$urandom(), $urandom()};
            step("rnd");
        end

        // Asynchronous reset with entries held.
        in_flush = 1'b0; in_ready = 1'b0;
        drive_req(64'h800, 64'h4); step("mrst");
        drive_req(64'h900, 64'h4); step("mrst");
        #2 in_rst_n = 1'b0;
        #1;
        mq.delete(); exp_cnt = 0; exp_mcnt = 0;
        check_outputs("mrst_async");
        chk("mrst_pcnext", out_pc_next, 0);
        chk("mrst_taken", DW'(out_taken), 0);
        in_valid = 1'b0;
        #2 in_rst_n = 1'b1;
        in_ready = 1'b1;
        step("mrst_post");
        step("mrst_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
